// File: rtl/va_037_pkg.sv
// va_037 shared types: FSM states, grant kinds, output bundle.
// Output decode lives here so the arbiter registers it directly.
package va_037_pkg;

  localparam int ROW_W  = 7;
  localparam int ADDR_W = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAS,
    S_CAS1,
    S_CAS2,
    S_PRE,
    S_REF1,
    S_REF2
  } state_t;

  typedef enum logic [1:0] {
    GNT_VID,
    GNT_REF,
    GNT_CPU
  } gnt_t;

  typedef struct packed {
    logic [ROW_W-1:0] a;
    logic             nras;
    logic [1:0]       ncas;
    logic             nwe;
    logic             wti;
    logic             wtd;
    logic             stb;
    logic             ack;
  } dram_o_t;

  localparam dram_o_t O_RST = '{
    a: '0, nras: 1'b1, ncas: 2'b11, nwe: 1'b1,
    wti: 1'b0, wtd: 1'b0, stb: 1'b0, ack: 1'b0
  };

  function automatic dram_o_t dec(
    input state_t            s,
    input gnt_t              g,
    input logic              we,
    input logic [1:0]        be,
    input logic [ADDR_W-1:0] ad,
    input logic [ROW_W-1:0]  rr
  );
    dram_o_t o;
    logic    cw;
    o  = O_RST;
    cw = (g == GNT_CPU) && we;
    unique case (s)
      S_RAS: begin
        o.a    = ad[ADDR_W-1:ROW_W];
        o.nras = 1'b0;
      end
      S_CAS1, S_CAS2: begin
        o.a    = ad[ROW_W-1:0];
        o.nras = 1'b0;
        o.ncas = cw ? ~be : 2'b00;
        o.nwe  = ~cw;
        if (s == S_CAS2) begin
          o.wti = (g == GNT_VID);
          o.stb = (g == GNT_VID);
          o.ack = (g == GNT_CPU);
          o.wtd = (g == GNT_CPU) && !we;
        end
      end
      S_REF1, S_REF2: begin
        o.a    = rr;
        o.nras = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/va_037_tick.sv
// Modulo-N wrap timer; held at zero while disabled.
// o_wrap is high during the last count, so the wrap edge is visible.
module va_037_tick #(
  parameter int N = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_wrap
);

  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == W'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || o_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/va_037_arb.sv
// DRAM arbiter/sequencer: video, refresh and CPU share one bank.
// Outputs are decoded from the next state and registered.
module va_037_arb
  import va_037_pkg::*;
#(
  parameter int VID_PERIOD = 16,
  parameter int REF_PERIOD = 64
) (
  input  logic              PIN_CLK,
  input  logic              PIN_nRST,
  input  logic              vid_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_stb,
  output logic              vid_ovr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [ROW_W-1:0]  PIN_A,
  output logic              PIN_nRAS,
  output logic [1:0]        PIN_nCAS,
  output logic              PIN_nWE,
  output logic              PIN_WTI,
  output logic              PIN_WTD
);

  state_t            r_state, w_nstate;
  gnt_t              r_gnt, w_ngnt;
  logic [ADDR_W-1:0] r_addr, w_naddr;
  logic              r_we, w_nwe;
  logic [1:0]        r_be, w_nbe;
  logic              r_vid_pend, r_ref_pend, r_ovr;
  logic [ROW_W-1:0]  r_ref_row;
  logic              w_vid_wrap, w_ref_wrap;
  logic              w_gnt_vid, w_gnt_ref;
  dram_o_t           r_o, w_o;

  va_037_tick #(.N(VID_PERIOD)) u_vid_tick (
    .i_clk   (PIN_CLK),
    .i_rst_n (PIN_nRST),
    .i_en    (vid_en),
    .o_wrap  (w_vid_wrap)
  );

  va_037_tick #(.N(REF_PERIOD)) u_ref_tick (
    .i_clk   (PIN_CLK),
    .i_rst_n (PIN_nRST),
    .i_en    (1'b1),
    .o_wrap  (w_ref_wrap)
  );

  assign w_gnt_vid = (r_state == S_IDLE) && r_vid_pend;
  assign w_gnt_ref = (r_state == S_IDLE) && !r_vid_pend
                     && r_ref_pend;

  always_comb begin
    w_nstate = r_state;
    w_ngnt   = r_gnt;
    w_naddr  = r_addr;
    w_nwe    = r_we;
    w_nbe    = r_be;
    unique case (r_state)
      S_IDLE: begin
        if (r_vid_pend) begin
          w_nstate = S_RAS;
          w_ngnt   = GNT_VID;
          w_naddr  = vid_addr;
          w_nwe    = 1'b0;
          w_nbe    = 2'b11;
        end else if (r_ref_pend) begin
          w_nstate = S_REF1;
          w_ngnt   = GNT_REF;
        end else if (cpu_req) begin
          w_nstate = S_RAS;
          w_ngnt   = GNT_CPU;
          w_naddr  = cpu_addr;
          w_nwe    = cpu_we;
          w_nbe    = cpu_be;
        end
      end
      S_RAS:   w_nstate = S_CAS1;
      S_CAS1:  w_nstate = S_CAS2;
      S_CAS2:  w_nstate = S_PRE;
      S_REF1:  w_nstate = S_REF2;
      S_REF2:  w_nstate = S_PRE;
      S_PRE:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    w_o = dec(w_nstate, w_ngnt, w_nwe, w_nbe, w_naddr, r_ref_row);
  end

  always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
    if (!PIN_nRST) begin
      r_state    <= S_IDLE;
      r_gnt      <= GNT_CPU;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= 2'b00;
      r_vid_pend <= 1'b0;
      r_ref_pend <= 1'b0;
      r_ovr      <= 1'b0;
      r_ref_row  <= '0;
      r_o        <= O_RST;
    end else begin
      r_state <= w_nstate;
      r_gnt   <= w_ngnt;
      r_addr  <= w_naddr;
      r_we    <= w_nwe;
      r_be    <= w_nbe;
      r_o     <= w_o;
      // a fresh wrap wins over the grant that clears the old one
      if (w_vid_wrap) begin
        r_vid_pend <= 1'b1;
      end else if (w_gnt_vid) begin
        r_vid_pend <= 1'b0;
      end
      if (w_vid_wrap && r_vid_pend && !w_gnt_vid) begin
        r_ovr <= 1'b1;
      end
      if (w_ref_wrap) begin
        r_ref_pend <= 1'b1;
      end else if (w_gnt_ref) begin
        r_ref_pend <= 1'b0;
      end
      if (r_state == S_REF2) begin
        r_ref_row <= r_ref_row + 1'b1;
      end
    end
  end

  assign PIN_A    = r_o.a;
  assign PIN_nRAS = r_o.nras;
  assign PIN_nCAS = r_o.ncas;
  assign PIN_nWE  = r_o.nwe;
  assign PIN_WTI  = r_o.wti;
  assign PIN_WTD  = r_o.wtd;
  assign vid_stb  = r_o.stb;
  assign cpu_ack  = r_o.ack;
  assign vid_ovr  = r_ovr;

endmodule

// File: tb/tb_va_037_arb.sv
// Directed bench for va_037_arb: CPU vector table plus
// hand sequences for video/refresh, overrun and mid-cycle reset.
module tb_va_037_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_en = 1'b0;
  logic [13:0] vid_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b11;
  logic [13:0] cpu_addr = '0;

  logic        vid_stb, vid_ovr, cpu_ack;
  logic [6:0]  A;
  logic        nRAS, nWE, WTI, WTD;
  logic [1:0]  nCAS;

  logic        o2_stb, o2_ovr, o2_ack;
  logic [6:0]  o2_A;
  logic        o2_nRAS, o2_nWE, o2_WTI, o2_WTD;
  logic [1:0]  o2_nCAS;

  always #5 clk = ~clk;

  va_037_arb #(.VID_PERIOD(16), .REF_PERIOD(64)) u_dut (
    .PIN_CLK(clk), .PIN_nRST(rst_n),
    .vid_en(vid_en), .vid_addr(vid_addr),
    .vid_stb(vid_stb), .vid_ovr(vid_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack), .PIN_A(A),
    .PIN_nRAS(nRAS), .PIN_nCAS(nCAS),
    .PIN_nWE(nWE), .PIN_WTI(WTI), .PIN_WTD(WTD)
  );

  va_037_arb #(.VID_PERIOD(4), .REF_PERIOD(64)) u_ovr (
    .PIN_CLK(clk), .PIN_nRST(rst_n),
    .vid_en(vid_en), .vid_addr(vid_addr),
    .vid_stb(o2_stb), .vid_ovr(o2_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_ack(o2_ack), .PIN_A(o2_A),
    .PIN_nRAS(o2_nRAS), .PIN_nCAS(o2_nCAS),
    .PIN_nWE(o2_nWE), .PIN_WTI(o2_WTI), .PIN_WTD(o2_WTD)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [14:0] pk(
    input logic [6:0] a, input logic ras,
    input logic [1:0] cas, input logic we,
    input logic wti, input logic wtd,
    input logic stb, input logic ack);
    return {a, ras, cas, we, wti, wtd, stb, ack};
  endfunction

  logic [14:0] obs;
  assign obs = {A, nRAS, nCAS, nWE, WTI, WTD, vid_stb, cpu_ack};

  localparam logic [14:0] IDLE_O = 15'b0000000_1_11_1_0000;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // event counters sampled at the clock edge
  int n_wti = 0, n_stb = 0, n_ack = 0, n_wtd = 0, n_badA = 0;
  always @(posedge clk) begin
    if (WTI) n_wti <= n_wti + 1;
    if (vid_stb) n_stb <= n_stb + 1;
    if (cpu_ack) n_ack <= n_ack + 1;
    if (WTD) n_wtd <= n_wtd + 1;
    if (WTI && A != 7'h7F) n_badA <= n_badA + 1;
  end

  // refresh cycles are the only nRAS-low runs of length 2
  int         run = 0;
  logic [6:0] a0;
  logic [6:0] refq[$];
  always @(negedge clk) begin
    if (!nRAS) begin
      if (run == 0) a0 <= A;
      run <= run + 1;
    end else begin
      if (run == 2) refq.push_back(a0);
      run <= 0;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [13:0] addr;
    logic [6:0]  row;
    logic [6:0]  col;
    logic [1:0]  ncas;
    logic        nwe;
    logic        wtd;
  } vec_t;

  vec_t vt[6];

  initial begin
    int s0, s1, s2, s3, s4, got, d;

    vt[0] = '{1'b0, 2'b11, 14'h1234, 7'h24, 7'h34, 2'b00, 1'b1, 1'b1};
    vt[1] = '{1'b1, 2'b10, 14'h2A55, 7'h54, 7'h55, 2'b01, 1'b0, 1'b0};
    vt[2] = '{1'b1, 2'b00, 14'h0080, 7'h01, 7'h00, 2'b11, 1'b0, 1'b0};
    vt[3] = '{1'b1, 2'b01, 14'h3F81, 7'h7F, 7'h01, 2'b10, 1'b0, 1'b0};
    vt[4] = '{1'b0, 2'b00, 14'h007F, 7'h00, 7'h7F, 2'b00, 1'b1, 1'b1};
    vt[5] = '{1'b1, 2'b11, 14'h0000, 7'h00, 7'h00, 2'b00, 1'b0, 1'b0};

    do_reset();
    #1;
    chk("reset_out", obs, IDLE_O);
    chk("reset_ovr", vid_ovr, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      cpu_we   = vt[i].we;
      cpu_be   = vt[i].be;
      cpu_addr = vt[i].addr;
      cpu_req  = 1'b1;
      step(1);
      chk($sformatf("v%0d_ras", i), obs,
          pk(vt[i].row, 0, 2'b11, 1, 0, 0, 0, 0));
      step(1);
      chk($sformatf("v%0d_cas1", i), obs,
          pk(vt[i].col, 0, vt[i].ncas, vt[i].nwe, 0, 0, 0, 0));
      step(1);
      chk($sformatf("v%0d_cas2", i), obs,
          pk(vt[i].col, 0, vt[i].ncas, vt[i].nwe,
             0, vt[i].wtd, 0, 1));
      cpu_req = 1'b0;
      step(1);
      chk($sformatf("v%0d_pre", i), obs, IDLE_O);
      step(2);
      chk($sformatf("v%0d_idle", i), obs, IDLE_O);
    end

    // request withdrawn before any edge sees it
    do_reset();
    cpu_we = 1'b0; cpu_addr = 14'h1234; cpu_req = 1'b1;
    #2 cpu_req = 1'b0;
    step(1);
    chk("cancel_nras", nRAS, 1);
    step(4);
    chk("cancel_idle", obs, IDLE_O);

    // request withdrawn after grant still completes
    do_reset();
    cpu_req = 1'b1;
    step(1);
    cpu_req = 1'b0;
    chk("late_drop_ras", nRAS, 0);
    step(2);
    chk("late_drop_ack", cpu_ack, 1);

    // reset pulse during CAS1 of a write
    do_reset();
    cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 14'h1234;
    cpu_req = 1'b1;
    step(2);
    chk("abort_cas1", {nCAS, nWE}, 3'b000);
    s0 = n_ack;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", obs, IDLE_O);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_ack", n_ack - s0, 0);
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      step(1);
      if (cpu_ack) got = k + 1;
    end
    chk("rereq_ack_lat", got, 3);
    cpu_req = 1'b0;

    // video/refresh collision at edge 64, then refresh row wrap
    do_reset();
    vid_en = 1'b1; vid_addr = 14'h3FFF; cpu_we = 1'b0;
    refq.delete();
    step(65);
    chk("vid_ras", obs, pk(7'h7F, 0, 2'b11, 1, 0, 0, 0, 0));
    step(2);
    chk("vid_cas2", obs, pk(7'h7F, 0, 2'b00, 1, 1, 0, 1, 0));
    step(3);
    chk("ref1_row0", obs, pk(7'h00, 0, 2'b11, 1, 0, 0, 0, 0));
    step(1);
    chk("ref2_row0", obs, pk(7'h00, 0, 2'b11, 1, 0, 0, 0, 0));
    step(1);
    chk("ref_pre", obs, IDLE_O);
    step(64 * 129);
    chk("ref_count", refq.size() >= 129, 1);
    if (refq.size() >= 129) begin
      chk("ref_row1", refq[1], 7'd1);
      chk("ref_row127", refq[127], 7'd127);
      chk("ref_wrap0", refq[128], 7'd0);
    end
    chk("ref_noovr", vid_ovr, 0);

    // continuous CPU reads with video running
    do_reset();
    cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 14'h1234;
    cpu_req = 1'b1;
    s0 = n_wti; s1 = n_stb; s2 = n_ack; s3 = n_wtd; s4 = n_badA;
    step(800);
    chk("ovr4_set_mid", o2_ovr, 1);
    step(800);
    d = n_wti - s0;
    chk("vid_rate", (d >= 98 && d <= 100), 1);
    chk("stb_eq_wti", n_stb - s1, d);
    chk("vid_col_7f", n_badA - s4, 0);
    chk("cpu_acks", (n_ack - s2) >= 150, 1);
    chk("wtd_eq_ack", n_wtd - s3, n_ack - s2);
    chk("ovr16_clear", vid_ovr, 0);
    chk("ovr4_set_end", o2_ovr, 1);
    cpu_req = 1'b0;
    vid_en  = 1'b0;
    do_reset();
    #1;
    chk("ovr4_reset", o2_ovr, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
